// File: rtl/numchar_ctl.sv
// numchar_ctl: sequencer for the MIX CHAR and NUM instructions.
// A start pulse captures rA, rX and the operation, then one decimal digit
// is processed per clock for ten clocks. Results are registered and held
// until the next completion. done pulses for one cycle.
//
// The two operations share one datapath:
//   acc : NUM accumulator, or the CHAR value being divided down
//   sr  : NUM source byte string shifting left, or the CHAR result
//         string shifting right
module numchar_ctl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        op,
   input  logic [30:0] a_in,
   input  logic [30:0] x_in,
   output logic [30:0] a_out,
   output logic [30:0] x_out,
   output logic        busy,
   output logic        done,
   output logic        ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  count;
   logic        op_q;      // 1 = CHAR, 0 = NUM
   logic        a_sign;
   logic        x_sign;
   logic [29:0] x_q;       // rX magnitude, returned unchanged by NUM
   logic [33:0] acc;
   logic [59:0] sr;

   logic        accept;
   logic        last_digit;
   logic [3:0]  num_digit;
   logic [33:0] num_acc_next;
   logic [3:0]  char_r;
   logic [33:0] char_v_next;
   logic [59:0] char_sr_next;

   assign accept     = (state == S_IDLE) && start;
   assign last_digit = (state == S_RUN) && (count == 4'd9);

   // Digit engine: both operations' next values, chosen by op_q below.
   // The NUM digit is the top byte of sr, the most significant byte not
   // yet consumed; the CHAR digit is the remainder of the running value.
   assign num_digit    = 4'(sr[59:54] % 6'd10);
   assign num_acc_next = acc * 34'd10 + {30'd0, num_digit};
   assign char_r       = 4'(acc % 34'd10);
   assign char_v_next  = acc / 34'd10;
   assign char_sr_next = {6'd30 + {2'b00, char_r}, sr[59:6]};

   // State register
   // NOTE: every clocked process uses non-blocking (<=) assignments so that
   // all registers update together from values sampled before the edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_next;
   end

   // Next-state logic: IDLE -> RUN on start, ten RUN cycles, one DONE cycle
   // NOTE: the default assignment first keeps this combinational process
   // free of inferred latches on every path through the case.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (count == 4'd9) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state register only
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_RUN:   busy = 1'b1;
         S_DONE:  begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   // Datapath: capture on accept, one digit per RUN cycle, load results
   // on the last digit so they appear together with done
   // NOTE: all datapath registers are plain flops (no memory arrays), so
   // each is cleared by the asynchronous reset, including the result outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count  <= 4'd0;
         op_q   <= 1'b0;
         a_sign <= 1'b0;
         x_sign <= 1'b0;
         x_q    <= 30'd0;
         acc    <= 34'd0;
         sr     <= 60'd0;
         a_out  <= 31'd0;
         x_out  <= 31'd0;
         ovf    <= 1'b0;
      end else begin
         if (accept) begin
            count  <= 4'd0;
            op_q   <= op;
            a_sign <= a_in[30];
            x_sign <= x_in[30];
            x_q    <= x_in[29:0];
            if (op) begin
               acc <= {4'd0, a_in[29:0]};
               sr  <= 60'd0;
            end else begin
               acc <= 34'd0;
               sr  <= {a_in[29:0], x_in[29:0]};
            end
         end else if (state == S_RUN) begin
            count <= (count == 4'd9) ? 4'd0 : count + 4'd1;
            if (op_q) begin
               acc <= char_v_next;
               sr  <= char_sr_next;
            end else begin
               acc <= num_acc_next;
               sr  <= {sr[53:0], 6'd0};
            end
         end

         if (last_digit) begin
            if (op_q) begin
               a_out <= {a_sign, char_sr_next[59:30]};
               x_out <= {x_sign, char_sr_next[29:0]};
               ovf   <= 1'b0;
            end else begin
               a_out <= {a_sign, num_acc_next[29:0]};
               x_out <= {x_sign, x_q};
               ovf   <= |num_acc_next[33:30];
            end
         end
      end
   end

endmodule

// File: tb/tb_numchar_ctl.sv
// Testbench for numchar_ctl: directed cases plus randomized operations.
// Expected results are pushed to a queue at issue time; a monitor pops and
// compares whenever done is seen. Timing of busy/done is checked inline.
module tb_numchar_ctl;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        op;
   logic [30:0] a_in;
   logic [30:0] x_in;
   logic [30:0] a_out;
   logic [30:0] x_out;
   logic        busy;
   logic        done;
   logic        ovf;

   typedef struct {
      logic [30:0] a;
      logic [30:0] x;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Last completed result, used to check that outputs are held during RUN
   exp_t last_res;

   numchar_ctl dut (
      .clk   (clk),
      .resetn(resetn),
      .start (start),
      .op    (op),
      .a_in  (a_in),
      .x_in  (x_in),
      .a_out (a_out),
      .x_out (x_out),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Build a word from a sign and five byte values
   function automatic logic [30:0] w(input bit s, input int b1, input int b2,
                                     input int b3, input int b4, input int b5);
      logic [5:0] c1, c2, c3, c4, c5;
      c1 = b1[5:0]; c2 = b2[5:0]; c3 = b3[5:0]; c4 = b4[5:0]; c5 = b5[5:0];
      return {s, c1, c2, c3, c4, c5};
   endfunction

   // Reference model at the instruction level
   function automatic exp_t model(input logic o, input logic [30:0] a, input logic [30:0] x);
      exp_t   r;
      longint v;
      int     bytes[10];
      logic [59:0] str;
      if (!o) begin
         v = 0;
         for (int k = 0; k < 10; k++) begin
            if (k < 5) bytes[k] = int'(a[29 - 6*k -: 6]);
            else       bytes[k] = int'(x[29 - 6*(k-5) -: 6]);
            v = v * 10 + (bytes[k] % 10);
         end
         r.a   = {a[30], 30'(v % 64'd1073741824)};
         r.x   = x;
         r.ovf = (v >= 64'd1073741824);
      end else begin
         v = longint'(a[29:0]);
         for (int k = 9; k >= 0; k--) begin
            bytes[k] = 30 + int'(v % 10);
            v = v / 10;
         end
         str = '0;
         for (int k = 0; k < 10; k++) str[59 - 6*k -: 6] = 6'(bytes[k]);
         r.a   = {a[30], str[59:30]};
         r.x   = {x[30], str[29:0]};
         r.ovf = 1'b0;
      end
      return r;
   endfunction

   // Monitor: every done must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (resetn && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("a_out", 64'(a_out), 64'(e.a));
            check("x_out", 64'(x_out), 64'(e.x));
            check("ovf",   64'(ovf),   64'(e.ovf));
            last_res = e;
         end
      end
   end

   // Issue one operation; must be called at a negative edge. Start is
   // sampled at the next rising edge (E). extra=1 pulses start again so it
   // is sampled at E+3, E+10 and E+11 (the done cycle), all to be ignored.
   // Returns at the negedge after E+11 with the DUT idle.
   task automatic do_op(input logic o, input logic [30:0] a, input logic [30:0] x,
                        input exp_t e, input bit extra);
      int   done_n;
      int   done_cnt;
      exp_t held;
      held     = last_res;
      op       = o;
      a_in     = a;
      x_in     = x;
      start    = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      start    = 1'b0;
      check("busy_after_start", 64'(busy), 64'(1));
      done_n   = -1;
      done_cnt = 0;
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         start = extra && (n == 2 || n == 9 || n == 10);
         // randomise the data inputs while busy; they must be ignored
         a_in = 31'($urandom);
         x_in = 31'($urandom);
         op   = 1'($urandom);
         if (done) begin
            done_cnt++;
            done_n = n;
         end
         if (n == 5) begin
            check("held_a", 64'(a_out), 64'(held.a));
            check("held_x", 64'(x_out), 64'(held.x));
            check("held_ovf", 64'(ovf), 64'(held.ovf));
         end
         if (n == 10) check("busy_in_done", 64'(busy), 64'(1));
         if (n == 11) begin
            check("busy_idle", 64'(busy), 64'(0));
            check("done_fell", 64'(done), 64'(0));
         end
      end
      start = 1'b0;
      check("done_count", 64'(done_cnt), 64'(1));
      check("done_latency", 64'(done_n), 64'(10));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_ovf"},  64'(ovf),  64'(0));
      check({tag, "_a"},    64'(a_out), 64'(0));
      check({tag, "_x"},    64'(x_out), 64'(0));
   endtask

   exp_t        e;
   logic        r_op;
   logic [30:0] r_a;
   logic [30:0] r_x;

   initial begin
      resetn   = 1'b0;
      start    = 1'b0;
      op       = 1'b0;
      a_in     = '0;
      x_in     = '0;
      last_res = '{a: '0, x: '0, ovf: 1'b0};
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      resetn = 1'b1;
      @(negedge clk);

      // CHAR of +12977699, rX negative
      e = '{a: w(0, 30, 30, 31, 32, 39), x: w(1, 37, 37, 36, 39, 39), ovf: 1'b0};
      do_op(1'b1, {1'b0, 30'd12977699}, w(1, 5, 6, 7, 8, 9), e, 1'b0);

      // NUM, Knuth example
      e = '{a: {1'b1, 30'd12977700}, x: w(0, 37, 57, 47, 30, 30), ovf: 1'b0};
      do_op(1'b0, w(1, 0, 0, 31, 32, 39), w(0, 37, 57, 47, 30, 30), e, 1'b0);

      // NUM overflow: 9 999 999 999 mod 2^30, with ignored start pulses
      e = '{a: {1'b0, 30'd336323583}, x: w(1, 39, 39, 39, 39, 39), ovf: 1'b1};
      do_op(1'b0, w(0, 39, 39, 39, 39, 39), w(1, 39, 39, 39, 39, 39), e, 1'b1);

      // CHAR of zero clears ovf, back-to-back with the previous operation
      e = '{a: w(1, 30, 30, 30, 30, 30), x: w(0, 30, 30, 30, 30, 30), ovf: 1'b0};
      do_op(1'b1, {1'b1, 30'd0}, w(0, 1, 2, 3, 4, 5), e, 1'b0);

      // Reset in the middle of a run
      op    = 1'b0;
      a_in  = w(0, 39, 39, 39, 39, 39);
      x_in  = w(0, 39, 39, 39, 39, 39);
      start = 1'b1;
      exp_q.push_back(model(1'b0, a_in, x_in));
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      #1;
      check_reset_state("midreset");
      exp_q.delete();
      last_res = '{a: '0, x: '0, ovf: 1'b0};
      repeat (2) @(negedge clk);
      check_reset_state("midreset_hold");
      resetn = 1'b1;
      @(negedge clk);

      // Randomised operations, mostly back-to-back, some with idle gaps
      for (int i = 0; i < 24; i++) begin
         r_op = 1'($urandom);
         r_a  = 31'($urandom);
         r_x  = 31'($urandom);
         if ((i % 4) == 1) begin
            // bias NUM bytes towards the character digits 30..39
            r_a = w(r_a[30], 30 + $urandom_range(0, 9), 30 + $urandom_range(0, 9),
                    30 + $urandom_range(0, 9), 30 + $urandom_range(0, 9), 30 + $urandom_range(0, 9));
         end
         do_op(r_op, r_a, r_x, model(r_op, r_a, r_x), (i % 5) == 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
